multiplicador_param: RTL and testbench

MULTIPLICADOR_PARAM -- requirements
Module: multiplicador_param

---
 rtl/multiplicador_param.sv | 126 ++++++++++++
 tb/tb_multiplicador_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_param.sv
// Sequential shift-and-add multiplier, WIDTH-bit operands, signed or unsigned, 2*WIDTH-bit result.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module multiplicador_param #(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_en,
    input  logic [WIDTH-1:0]     multiplicando,
    input  logic [WIDTH-1:0]     multiplicador2,
    output logic [2*WIDTH-1:0]   produto,
    output logic                 Idle,
    output logic                 Done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     mag_a;
    logic                 neg;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic [WIDTH-1:0]     mag_a_in, mag_b_in;
    logic                 neg_in;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step, acc_final;
    logic                 last_step;
`ifdef MULT_EARLY_TERM_EN
    logic [WIDTH-1:0]     rest_mask;
`endif

    // Operand conditioning and one shift-and-add step of the datapath.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        mag_a_in  = (signed_en && multiplicando[WIDTH-1])  ? -multiplicando  : multiplicando;
        mag_b_in  = (signed_en && multiplicador2[WIDTH-1]) ? -multiplicador2 : multiplicador2;
        neg_in    = signed_en & (multiplicando[WIDTH-1] ^ multiplicador2[WIDTH-1]);
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        acc_step  = {sum, acc[WIDTH-1:1]};
`ifdef MULT_EARLY_TERM_EN
        // Unconsumed multiplier bits sit just above acc[0]; once they are all zero the
        // remaining steps are pure shifts and can be collapsed into one.
        rest_mask = {WIDTH{1'b1}} >> (cnt + CW'(1));
        last_step = ((acc[WIDTH-1:0] >> 1) & rest_mask) == '0;
        acc_final = acc_step >> (WIDTH - 1 - int'(cnt));
`else
        last_step = (cnt == CW'(WIDTH - 1));
        acc_final = acc_step;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Idle       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                Idle = 1'b1;
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            mag_a   <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            produto <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= mag_a_in;
                        neg   <= neg_in;
                        acc   <= {{WIDTH{1'b0}}, mag_b_in};
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_final;
                    cnt <= cnt + CW'(1);
                    // A zero magnitude negates to zero, so no -0 artefact is possible.
                    if (last_step) begin
                        produto <= neg ? -acc_final : acc_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_param.sv
// Scoreboard bench for multiplicador_param: stimulus pushes expected product and Done cycle,
// a negedge monitor pops and compares on every Done pulse.
module tb_multiplicador_param;

    localparam int W = 16;

    logic             clock = 1'b0;
    logic             rst;
    logic             start;
    logic             signed_en;
    logic [W-1:0]     a, b;
    logic [2*W-1:0]   produto;
    logic             Idle, Done;

    typedef struct {
        logic [2*W-1:0] prod;
        int             done_cyc;
    } exp_t;

    exp_t           sb_q[$];
    exp_t           e_mon;
    int             cyc = 0;
    int             n_pass = 0;
    int             n_total = 0;
    int             n_done = 0;
    logic [2*W-1:0] prev_prod = '0;

    multiplicador_param #(.WIDTH(W)) dut (
        .clock          (clock),
        .rst            (rst),
        .start          (start),
        .signed_en      (signed_en),
        .multiplicando  (a),
        .multiplicador2 (b),
        .produto        (produto),
        .Idle           (Idle),
        .Done           (Done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
        longint px, py, p;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        p  = px * py;
        return p[2*W-1:0];
    endfunction

    // Cycles from the start-sampling edge to the Done cycle, counting both.
    function automatic int lat_model(input logic [W-1:0] y, input logic s);
        int lat;
        logic [W-1:0] mag;
        mag = (s && y[W-1]) ? -y : y;
        lat = W + 1;
`ifdef MULT_EARLY_TERM_EN
        lat = 2;
        for (int i = 0; i < W; i++) if (mag[i]) lat = i + 2;
`endif
        if (mag == '0 && lat != 2 && lat != W + 1) lat = W + 1;
        return lat;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = W'(1);
            2:       v = '1;
            3:       v = {1'b1, {(W-1){1'b0}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                         input logic [2*W-1:0] exp_prod, input bit hold_start, output int exp_cyc);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clock);
        while (!Idle && waited < 4 * W) begin
            @(negedge clock);
            waited++;
        end
        check("idle_wait", Idle, 1);
        a = ia;
        b = ib;
        signed_en = is;
        start = 1'b1;
        @(posedge clock);
        #1;
        e.prod     = exp_prod;
        e.done_cyc = cyc + lat_model(ib, is) - 1;
        sb_q.push_back(e);
        exp_cyc = e.done_cyc;
        check("busy_after_start", Idle, 0);
        if (!hold_start) start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 8 * W) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", sb_q.size(), 0);
    endtask

    // Monitor: every Done must match the oldest pending expectation; produto must hold otherwise.
    always @(negedge clock) begin
        if (!rst) begin
            if (Done) begin
                check("done_has_pending_op", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e_mon = sb_q.pop_front();
                    check("produto", produto, e_mon.prod);
                    check("done_cycle", cyc, e_mon.done_cyc);
                end
                check("idle_low_in_done", Idle, 0);
                n_done++;
            end else begin
                check("produto_hold", produto, prev_prod);
            end
        end
        prev_prod = produto;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, e2, ec, done_before, lat;
        logic [W-1:0] ra, rb;
        logic         rs;

        rst = 1'b1;
        start = 1'b0;
        signed_en = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clock);
        rst = 1'b0;
        #1;
        check("reset_produto", produto, 0);
        check("reset_idle", Idle, 1);
        check("reset_done", Done, 0);

        // Directed vectors with hand-derived products.
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0, ec);
        do_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, ec);
        do_op(16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, 0, ec);
        do_op(16'h1234, 16'h0000, 1'b0, 32'h00000000, 0, ec);
        do_op(16'hFFFF, 16'h0000, 1'b1, 32'h00000000, 0, ec);
        do_op(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 0, ec);
        do_op(16'h8000, 16'hFFFF, 1'b1, 32'h00008000, 0, ec);
        do_op(16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001, 0, ec);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 0, ec);
        do_op(16'h0000, 16'hFFFF, 1'b1, 32'h00000000, 0, ec);
        do_op(16'h8000, 16'h8000, 1'b0, 32'h40000000, 0, ec);
        drain();

        // Reset in the middle of CALC aborts the operation without a Done.
        @(negedge clock);
        @(negedge clock);
        done_before = n_done;
        a = 16'h1234;
        b = 16'h00FF;
        signed_en = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #2;
        rst = 1'b1;
        #1;
        check("abort_produto", produto, 0);
        check("abort_idle", Idle, 1);
        check("abort_done", Done, 0);
        @(negedge clock);
        #2;
        rst = 1'b0;
        repeat (2 * W) @(negedge clock);
        check("abort_no_done", n_done, done_before);
        do_op(16'd3, 16'd5, 1'b0, 32'd15, 0, ec);
        drain();

        // start held high: back-to-back operations.
        do_op(16'd2, 16'd3, 1'b0, 32'd6, 1, e1);
        do_op(16'd2, 16'd3, 1'b0, 32'd6, 1, e2);
        start = 1'b0;
        check("b2b_spacing", e2 - e1, lat_model(16'd3, 1'b0) + 1);
        drain();

        // start and operands toggled during CALC must not disturb the running operation.
        lat = lat_model(16'h1357, 1'b1);
        do_op(16'hCABC, 16'h1357, 1'b1, ref_mul(16'hCABC, 16'h1357, 1'b1), 0, ec);
        for (int i = 0; i < lat - 3; i++) begin
            @(negedge clock);
            start = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            signed_en = 1'($urandom);
        end
        start = 1'b0;
        drain();

        // Randomised operands in both modes against the reference product.
        for (int i = 0; i < 2500; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            rs = 1'($urandom);
            do_op(ra, rb, rs, ref_mul(ra, rb, rs), 0, ec);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
